// File: rtl/lcd_dma_fifo_banked.sv
// Banked show-ahead FIFO feeding the LCD engine: TFT fills banks sequentially, STN interleaves words across banks.
// Head word appears on data_out the cycle after it is written; rejected push/pull set sticky ovf/udf; dma_req tracks free space.
module lcd_dma_fifo_banked #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int NBANKS = 2,
  localparam int TOTAL = DEPTH * NBANKS,
  localparam int CW    = $clog2(TOTAL) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tft_mode,
  input  logic [CW-1:0]    watermark,
  input  logic             fp_pulse,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pull,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    level,
  output logic             dma_req,
  output logic             ovf,
  output logic             udf,
  input  logic             clr_err
);

  localparam int AW = CW - 1;
  localparam int DW = $clog2(DEPTH);
  localparam int SB = $clog2(NBANKS);
  localparam int BW = (NBANKS > 1) ? SB : 1;

  logic [WIDTH-1:0] mem_q [NBANKS][DEPTH];

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          tft_mode_q, tft_mode_d;
  logic          run_q, run_d;

  logic          mode;
  logic          pull_ok, push_ok, wr_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [CW-1:0] wm_eff, thr_bank;
  logic          bank_hit;

  function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] a, input logic m);
    return BW'(m ? (a >> DW) : (a & AW'(NBANKS - 1)));
  endfunction

  function automatic logic [DW-1:0] index_of(input logic [AW-1:0] a, input logic m);
    return DW'(m ? (a & AW'(DEPTH - 1)) : (a >> SB));
  endfunction

  function automatic int overlap(input int s, input int e, input int lo, input int hi);
    int a;
    int z;
    a = (s > lo) ? s : lo;
    z = (e < hi) ? e : hi;
    return (z > a) ? (z - a) : 0;
  endfunction

  // Occupied span is [rd, rd+level) unrolled over two laps, so each bank is tested twice.
  function automatic logic [CW-1:0] bank_free(input int b, input logic [AW-1:0] ra, input logic [CW-1:0] lv);
    int s;
    int e;
    int lo;
    int occ;
    s   = int'(ra);
    e   = s + int'(lv);
    lo  = b * DEPTH;
    occ = overlap(s, e, lo, lo + DEPTH) + overlap(s, e, lo + TOTAL, lo + TOTAL + DEPTH);
    return CW'(DEPTH - occ);
  endfunction

  // Until the first edge after reset the mode input itself is the effective mode.
  assign mode    = run_q ? tft_mode_q : tft_mode;
  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];

  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (level == '0);
  assign full     = (level == CW'(TOTAL));
  assign ovf      = ovf_q;
  assign udf      = udf_q;
  assign data_out = empty ? '0 : mem_q[bank_of(rd_addr, mode)][index_of(rd_addr, mode)];

  always_comb begin
    wm_eff = watermark;
    if (watermark == '0) begin
      wm_eff = CW'(1);
    end else if (watermark > CW'(TOTAL)) begin
      wm_eff = CW'(TOTAL);
    end
    thr_bank = (wm_eff > CW'(DEPTH)) ? CW'(DEPTH) : wm_eff;
  end

  always_comb begin
    bank_hit = 1'b0;
    for (int b = 0; b < NBANKS; b++) begin
      if (bank_free(b, rd_addr, level) >= thr_bank) begin
        bank_hit = 1'b1;
      end
    end
  end

  assign dma_req = rst & (mode ? bank_hit : ((CW'(TOTAL) - level) >= wm_eff));

  always_comb begin
    pull_ok    = pull & ~empty;
    push_ok    = push & (~full | pull_ok);
    wr_en      = push_ok & ~fp_pulse;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q & ~clr_err;
    udf_d      = udf_q & ~clr_err;
    tft_mode_d = run_q ? tft_mode_q : tft_mode;
    run_d      = 1'b1;
    if (fp_pulse) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      tft_mode_d = tft_mode;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + CW'(1);
      if (pull_ok) rd_ptr_d = rd_ptr_q + CW'(1);
      if (push && !push_ok) ovf_d = 1'b1;
      if (pull && !pull_ok) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      tft_mode_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      tft_mode_q <= tft_mode_d;
      run_q      <= run_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[bank_of(wr_addr, mode)][index_of(wr_addr, mode)] <= data_in;
    end
  end

endmodule

// File: tb/tb_lcd_dma_fifo_banked.sv
// Bench for lcd_dma_fifo_banked at default parameters (TOTAL = 32).
module tb_lcd_dma_fifo_banked;

  localparam int CW = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tft_mode = 1'b1;
  logic [5:0]  watermark = 6'd8;
  logic        fp_pulse = 1'b0;
  logic        push = 1'b0;
  logic [31:0] data_in = '0;
  logic        pull = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] data_out;
  logic        empty, full, dma_req, ovf, udf;
  logic [5:0]  level;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  lcd_dma_fifo_banked #(.WIDTH(32), .DEPTH(16), .NBANKS(2)) dut (
    .clk(clk), .rst(rst), .tft_mode(tft_mode), .watermark(watermark),
    .fp_pulse(fp_pulse), .push(push), .data_in(data_in), .pull(pull),
    .data_out(data_out), .empty(empty), .full(full), .level(level),
    .dma_req(dma_req), .ovf(ovf), .udf(udf), .clr_err(clr_err)
  );

  // One clock of push/pull with the reference queue updated by the same acceptance rules.
  task automatic step(input bit p, input logic [31:0] d, input bit q);
    bit pull_ok;
    bit push_ok;
    pull_ok = q && (sb.size() > 0);
    push_ok = p && ((sb.size() < 32) || pull_ok);
    push = p; data_in = d; pull = q;
    @(posedge clk); #1;
    push = 1'b0; pull = 1'b0;
    if (pull_ok) void'(sb.pop_front());
    if (push_ok) sb.push_back(d);
  endtask

  task automatic flush_cycle(input bit p);
    fp_pulse = 1'b1; push = p; data_in = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    fp_pulse = 1'b0; push = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset;
    #12;
    checks++; if ({empty, full, dma_req, ovf, udf} !== 5'b10000) begin errors++; $display("FAIL reset_flags got=%b exp=10000", {empty, full, dma_req, ovf, udf}); end
    checks++; if (level !== 6'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL reset_data got=%0h exp=0", data_out); end
    @(negedge clk); rst = 1'b1;
    step(1, 32'hA5A5_0001, 0);
    checks++; if (level !== 6'd1) begin errors++; $display("FAIL first_push_level got=%0d exp=1", level); end
    checks++; if (data_out !== sb[0]) begin errors++; $display("FAIL first_push_data got=%0h exp=%0h", data_out, sb[0]); end
    step(0, 0, 1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL first_pull_empty got=%b exp=1", empty); end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 32; i++) step(1, i, 0);
    checks++; if ({full, level} !== {1'b1, 6'd32}) begin errors++; $display("FAIL fill_full got=%b/%0d exp=1/32", full, level); end
    step(1, 32'd99, 0);
    checks++; if ({ovf, level} !== {1'b1, 6'd32}) begin errors++; $display("FAIL fill_ovf got=%b/%0d exp=1/32", ovf, level); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (data_out !== sb[0]) begin errors++; $display("FAIL drain_data got=%0h exp=%0h", data_out, sb[0]); end
      step(0, 0, 1);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    clr_err = 1'b1; step(0, 0, 0); clr_err = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fill_clr_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_watermark;
    tft_mode = 1'b0; flush_cycle(0);
    watermark = 6'd8;
    for (int i = 0; i < 24; i++) step(1, 32'd100 + i, 0);
    checks++; if (dma_req !== 1'b1) begin errors++; $display("FAIL wm_24 got=%b exp=1", dma_req); end
    step(1, 32'd124, 0);
    checks++; if (dma_req !== 1'b0) begin errors++; $display("FAIL wm_25 got=%b exp=0", dma_req); end
    watermark = 6'd0; #1;
    checks++; if (dma_req !== 1'b1) begin errors++; $display("FAIL wm_zero got=%b exp=1", dma_req); end
    watermark = 6'd40; #1;
    checks++; if (dma_req !== 1'b0) begin errors++; $display("FAIL wm_clamp got=%b exp=0", dma_req); end
  endtask

  task automatic test_mode_ignore;
    watermark = 6'd20; flush_cycle(0);
    for (int i = 0; i < 16; i++) step(1, 32'd300 + i, 0);
    checks++; if (dma_req !== 1'b0) begin errors++; $display("FAIL stn_16 got=%b exp=0", dma_req); end
    tft_mode = 1'b1; step(0, 0, 0);
    checks++; if (dma_req !== 1'b0) begin errors++; $display("FAIL mode_ignored got=%b exp=0", dma_req); end
    flush_cycle(0);
    for (int i = 0; i < 16; i++) step(1, 32'd400 + i, 0);
    checks++; if ({dma_req, level} !== {1'b1, 6'd16}) begin errors++; $display("FAIL tft_after_fp got=%b/%0d exp=1/16", dma_req, level); end
  endtask

  task automatic test_bank_req;
    flush_cycle(0); watermark = 6'd8;
    for (int i = 0; i < 16; i++) step(1, 32'd200 + i, 0);
    for (int i = 0; i < 9; i++) begin
      checks++; if (data_out !== sb[0]) begin errors++; $display("FAIL bank_pull_data got=%0h exp=%0h", data_out, sb[0]); end
      step(0, 0, 1);
    end
    checks++; if ({dma_req, level} !== {1'b1, 6'd7}) begin errors++; $display("FAIL bank_req got=%b/%0d exp=1/7", dma_req, level); end
    for (int i = 0; i < 10; i++) step(1, 32'd216 + i, 0);
    watermark = 6'd10; #1;
    checks++; if (dma_req !== 1'b0) begin errors++; $display("FAIL bank_wm10 got=%b exp=0", dma_req); end
    watermark = 6'd9; #1;
    checks++; if (dma_req !== 1'b1) begin errors++; $display("FAIL bank_wm9 got=%b exp=1", dma_req); end
  endtask

  task automatic test_boundaries;
    flush_cycle(0);
    step(1, 32'h0B0B_0000, 1);
    checks++; if ({level, udf, ovf} !== {6'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL empty_pushpull got=%0d/%b/%b exp=1/1/0", level, udf, ovf); end
    clr_err = 1'b1; step(0, 0, 0); clr_err = 1'b0;
    checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL clr_udf got=%b exp=00", {ovf, udf}); end
    for (int i = 1; i < 32; i++) step(1, 32'h0B0B_0000 + i, 0);
    checks++; if (data_out !== sb[0]) begin errors++; $display("FAIL full_head got=%0h exp=%0h", data_out, sb[0]); end
    step(1, 32'h0C0C_0000, 1);
    checks++; if ({level, ovf, full} !== {6'd32, 1'b0, 1'b1}) begin errors++; $display("FAIL full_pushpull got=%0d/%b/%b exp=32/0/1", level, ovf, full); end
    step(1, 32'h0D0D_0000, 0);
    clr_err = 1'b1; step(1, 32'h0D0D_0001, 0); clr_err = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL clr_vs_new_err got=%b exp=1", ovf); end
    clr_err = 1'b1; step(0, 0, 0); clr_err = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%b exp=0", ovf); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (data_out !== sb[0]) begin errors++; $display("FAIL bound_drain got=%0h exp=%0h", data_out, sb[0]); end
      step(0, 0, 1);
    end
  endtask

  task automatic test_back_to_back;
    tft_mode = 1'b0; flush_cycle(0);
    for (int i = 0; i < 3; i++) step(1, $urandom, 0);
    for (int i = 0; i < 20; i++) begin
      checks++; if (data_out !== sb[0]) begin errors++; $display("FAIL b2b_data got=%0h exp=%0h", data_out, sb[0]); end
      step(1, $urandom, 1);
    end
    checks++; if (level !== 6'd3) begin errors++; $display("FAIL b2b_level got=%0d exp=3", level); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (data_out !== sb[0]) begin errors++; $display("FAIL b2b_drain got=%0h exp=%0h", data_out, sb[0]); end
      step(0, 0, 1);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_flush;
    tft_mode = 1'b1; flush_cycle(0);
    for (int i = 0; i < 20; i++) step(1, 32'd500 + i, 0);
    checks++; if (level !== 6'd20) begin errors++; $display("FAIL flush_pre got=%0d exp=20", level); end
    flush_cycle(1);
    checks++; if ({level, empty, ovf} !== {6'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL flush_post got=%0d/%b/%b exp=0/1/0", level, empty, ovf); end
    checks++; if (data_out !== 32'd0) begin errors++; $display("FAIL flush_data got=%0h exp=0", data_out); end
  endtask

  task automatic test_async_reset;
    watermark = 6'd8;
    for (int i = 0; i < 5; i++) step(1, 32'd600 + i, 0);
    checks++; if (dma_req !== 1'b1) begin errors++; $display("FAIL arst_pre got=%b exp=1", dma_req); end
    #3 rst = 1'b0;
    #1;
    checks++; if ({level, dma_req, empty} !== {6'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL arst_now got=%0d/%b/%b exp=0/0/1", level, dma_req, empty); end
    sb.delete();
    @(negedge clk); rst = 1'b1;
    step(1, 32'd700, 0);
    checks++; if ({level, data_out} !== {6'd1, 32'd700}) begin errors++; $display("FAIL arst_first got=%0d/%0h exp=1/2bc", level, data_out); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_watermark();
    test_mode_ignore();
    test_bank_req();
    test_boundaries();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_dma_fifo_banked.md
LCD_DMA_FIFO_BANKED -- requirements
Module: lcd_dma_fifo_banked

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 16, entries per bank; power of two, at least 4.
REQ-003 Parameter NBANKS, default 2, bank count; power of two, at least 1; TOTAL = DEPTH*NBANKS; CW = clog2(TOTAL)+1.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 tft_mode  input  1  1 = sequential bank fill (TFT); 0 = word-interleaved round-robin across banks (STN).
REQ-007 watermark  input  CW  programmable free-entry threshold for DMA request.
REQ-008 fp_pulse  input  1  frame pulse; synchronous flush.
REQ-009 push  input  1  write request; data_in written when accepted.
REQ-010 data_in  input  WIDTH  write data.
REQ-011 pull  input  1  read request; pops head when accepted.
REQ-012 data_out  output  WIDTH  head word (show-ahead); 0 when empty.
REQ-013 empty / full  output  1 each  occupancy == 0 / occupancy == TOTAL.
REQ-014 level  output  CW  current occupancy.
REQ-015 dma_req  output  1  DMA refill request.
REQ-016 ovf / udf  output  1 each  sticky overflow / underflow flags.
REQ-017 clr_err  input  1  synchronous clear of ovf and udf.

Function
REQ-018 Storage SHALL be NBANKS register banks of DEPTH x WIDTH; write/read pointers are CW-bit wrap counters over 0..TOTAL-1 with the extra bit distinguishing full from empty.
REQ-019 Address map, tft_mode_q=1: bank = ptr / DEPTH, index = ptr mod DEPTH; tft_mode_q=0: bank = ptr mod NBANKS, index = ptr / NBANKS.
REQ-020 tft_mode SHALL be sampled into tft_mode_q only at reset release and on fp_pulse; changes at any other time SHALL be ignored.
REQ-021 pull is accepted when !empty; an accepted pull advances the read pointer at the clock edge, and data_out shows the new head in the next cycle.
REQ-022 push is accepted when !full or when a pull is accepted in the same cycle; an accepted push writes data_in and advances the write pointer.
REQ-023 Simultaneous push and pull both accepted: level unchanged.
REQ-024 Simultaneous push and pull while empty: push accepted, pull rejected, udf set.
REQ-025 Rejected push SHALL set ovf and leave data and pointers unchanged; rejected pull SHALL set udf.
REQ-026 ovf and udf SHALL stay set until clr_err; clr_err in the same cycle as a new error leaves the flag set.
REQ-027 fp_pulse SHALL zero both pointers and level next edge, overriding push and pull in that cycle, and SHALL NOT set ovf or udf.
REQ-028 Effective threshold wm_eff = max(1, min(watermark, TOTAL)).
REQ-029 tft_mode_q=0: dma_req = (TOTAL - level) >= wm_eff.
REQ-030 tft_mode_q=1: dma_req = 1 when any bank's free count is >= min(wm_eff, DEPTH); bank free counts are derived from the pointers.
REQ-031 dma_req, empty, full and level SHALL be combinational from registered state only, with no combinational path from push or pull.

Reset
REQ-032 When rst is low: pointers, level, ovf and udf = 0; empty = 1; full = 0; dma_req = 0; data_out = 0; tft_mode_q = tft_mode.
REQ-033 rst asserted mid-burst SHALL discard all contents immediately (asynchronous); bank contents need not be cleared.
REQ-034 The first push SHALL be accepted on the first rising edge after rst goes high.

Verification (defaults, TOTAL = 32)
REQ-035 Fill/drain, tft_mode=1: push 0..31 -> full=1, level=32; push 33rd word -> ovf=1; pull 32 times -> data 0..31 in order, empty=1.
REQ-036 Watermark, tft_mode=0: watermark=8, push 24 words -> dma_req=1 (8 free); push 25th -> dma_req=0.
REQ-037 Bank request, tft_mode=1: watermark=8, push 16 words then pull 9 -> dma_req=1; bank0 has 9 free >= 8 although total free is 25.
REQ-038 Boundaries: push+pull while empty -> level=1, udf=1; push+pull while full -> level=32, ovf=0; clr_err -> flags = 0.
REQ-039 Flush: level=20, fp_pulse with push=1 -> next cycle level=0, empty=1, ovf=0; tft_mode toggled mid-frame is ignored until the next fp_pulse.
REQ-040 Async reset: rst low between edges mid-fill -> level=0, dma_req=0 immediately, without waiting for a clock edge.
